// File: rtl/shift_sequencer_if.sv
// ---------------------------------------------------------------------------
// shift_sequencer_if
// Bundles the request port, the shifter drive/return path and the response
// port of shift_sequencer.
//   master modport : request producer / response consumer / shifter owner
//   slave  modport : the sequencer itself
// Signals:
//   req_valid/req_ready/req_data/req_amt   request handshake
//   sh_in/sh_ctrl/sh_out                   barrel-shifter data, amount, result
//   rsp_valid/rsp_ready/rsp_data/rsp_passes response handshake
//   busy                                   sequencer occupied
// ---------------------------------------------------------------------------
interface shift_sequencer_if #(
    parameter int AMT_W  = 5,
    parameter int PCNT_W = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [7:0]        req_data;
    logic [AMT_W-1:0]  req_amt;
    logic [7:0]        sh_in;
    logic [2:0]        sh_ctrl;
    logic [7:0]        sh_out;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [7:0]        rsp_data;
    logic [PCNT_W-1:0] rsp_passes;
    logic              busy;

    modport master (
        output req_valid, req_data, req_amt, sh_out, rsp_ready,
        input  req_ready, sh_in, sh_ctrl, rsp_valid, rsp_data, rsp_passes, busy
    );

    modport slave (
        input  req_valid, req_data, req_amt, sh_out, rsp_ready,
        output req_ready, sh_in, sh_ctrl, rsp_valid, rsp_data, rsp_passes, busy
    );
endinterface

// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
// Multi-pass controller for an external 8-bit logical-right barrel shifter
// that moves at most 7 positions per pass. A byte and a total amount are
// accepted on the request port; the byte is looped through the shifter,
// 7 positions at a time, until the full amount is applied, then the result
// and the number of passes used are offered on the response port.
//
// Ports:
//   clk  - clock, rising-edge
//   rst  - synchronous active-high reset
//   bus  - shift_sequencer_if.slave (request, shifter path, response, busy)
//
// Optional build macro:
//   SHIFT_SEQ_EARLY_ZERO_EN - any remaining amount >= 8 flushes the byte to
//   zero in a single pass instead of iterating.
// ---------------------------------------------------------------------------
module shift_sequencer #(
    parameter int AMT_W  = 5,
    parameter int PCNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    shift_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_reg,  state_next;
    logic [7:0]        data_reg,   data_next;
    logic [AMT_W-1:0]  rem_reg,    rem_next;
    logic [PCNT_W-1:0] pcnt_reg,   pcnt_next;

    logic [2:0]        step;
    logic [AMT_W-1:0]  rem_after;
    logic [PCNT_W-1:0] pcnt_inc;

    // Amount applied this pass never exceeds what is left, so rem cannot wrap.
    always_comb begin
        step      = (rem_reg >= AMT_W'(7)) ? 3'd7 : rem_reg[2:0];
        rem_after = rem_reg - AMT_W'(step);
        pcnt_inc  = (pcnt_reg == '1) ? pcnt_reg : pcnt_reg + PCNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            data_reg  <= '0;
            rem_reg   <= '0;
            pcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            rem_reg   <= rem_next;
            pcnt_reg  <= pcnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        rem_next   = rem_reg;
        pcnt_next  = pcnt_reg;

        unique case (state_reg)
            IDLE: begin
                if (bus.req_valid) begin
                    data_next  = bus.req_data;
                    rem_next   = bus.req_amt;
                    pcnt_next  = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                // A zero amount still makes one identity pass.
                data_next = bus.sh_out;
                rem_next  = rem_after;
                pcnt_next = pcnt_inc;
                if (rem_after == '0) begin
                    state_next = DONE;
                end
`ifdef SHIFT_SEQ_EARLY_ZERO_EN
                // Eight or more positions always empty a byte: finish now.
                if ({1'b0, rem_reg} >= (AMT_W + 1)'(8)) begin
                    data_next  = '0;
                    rem_next   = '0;
                    state_next = DONE;
                end
`endif
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = (state_reg == IDLE);
        bus.busy       = (state_reg != IDLE);
        bus.sh_in      = data_reg;
        bus.sh_ctrl    = (state_reg == SHIFT) ? step : 3'd0;
        bus.rsp_valid  = (state_reg == DONE);
        bus.rsp_data   = (state_reg == DONE) ? data_reg : 8'd0;
        bus.rsp_passes = (state_reg == DONE) ? pcnt_reg : '0;
    end
endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;
    localparam int AMT_W  = 5;
    localparam int PCNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    shift_sequencer_if #(.AMT_W(AMT_W), .PCNT_W(PCNT_W)) bus ();

    shift_sequencer #(.AMT_W(AMT_W), .PCNT_W(PCNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Stand-in for the 3-stage logical-right barrel shifter.
    assign bus.sh_out = bus.sh_in >> bus.sh_ctrl;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: passes and per-pass shift amounts from plain arithmetic.
    function automatic int model_passes(input int amt);
`ifdef SHIFT_SEQ_EARLY_ZERO_EN
        return 1;
`else
        return (amt == 0) ? 1 : (amt + 6) / 7;
`endif
    endfunction

    function automatic int model_step(input int amt, input int pass);
        int p;
        p = model_passes(amt);
`ifdef SHIFT_SEQ_EARLY_ZERO_EN
        return (amt >= 7) ? 7 : amt;
`else
        return (pass < p - 1) ? 7 : amt - 7 * (p - 1);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input logic [7:0] d, input int amt, input int hold);
        int          p;
        logic [7:0]  exp_data;
        logic [31:0] wide;
        p        = model_passes(amt);
        wide     = {24'd0, d} >> amt;
        exp_data = wide[7:0];
        check("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_data  = d;
        bus.req_amt   = AMT_W'(amt);
        tick();
        bus.req_valid = 1'b0;
        for (int k = 0; k < p; k++) begin
            check("sh_ctrl", 32'(bus.sh_ctrl), 32'(model_step(amt, k)));
            check("rsp_valid_early", 32'(bus.rsp_valid), 32'd0);
            tick();
        end
        check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("rsp_data", 32'(bus.rsp_data), 32'(exp_data));
        check("rsp_passes", 32'(bus.rsp_passes), 32'(p));
        for (int h = 0; h < hold; h++) begin
            bus.req_valid = 1'b1;
            bus.req_data  = ~d;
            bus.req_amt   = AMT_W'(1);
            tick();
            check("hold_req_ready", 32'(bus.req_ready), 32'd0);
            check("hold_rsp_data", 32'(bus.rsp_data), 32'(exp_data));
            check("hold_rsp_passes", 32'(bus.rsp_passes), 32'(p));
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("back_idle_ready", 32'(bus.req_ready), 32'd1);
        check("back_idle_busy", 32'(bus.busy), 32'd0);
        $display("txn data=%02h amt=%0d hold=%0d -> exp %02h passes %0d", d, amt, hold, exp_data, p);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_data  = 8'd0;
        bus.req_amt   = '0;
        bus.rsp_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("rst_rsp_passes", 32'(bus.rsp_passes), 32'd0);
        check("rst_sh_in", 32'(bus.sh_in), 32'd0);
        check("rst_sh_ctrl", 32'(bus.sh_ctrl), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);

        run_txn(8'hB5, 3, 0);
        run_txn(8'hB5, 0, 0);
        run_txn(8'hFF, 10, 0);
        run_txn(8'h80, 7, 5);

        // Reset in the second SHIFT cycle of a long request.
        bus.req_valid = 1'b1;
        bus.req_data  = 8'hFF;
        bus.req_amt   = AMT_W'(20);
        tick();
        bus.req_valid = 1'b0;
        check("mid_busy", 32'(bus.busy), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_sh_ctrl", 32'(bus.sh_ctrl), 32'd0);
        $display("txn mid-operation reset applied");
        run_txn(8'h0F, 2, 0);

        run_txn(8'($urandom), 31, 1);

        for (int i = 0; i < 25; i++) begin
            run_txn(8'($urandom), int'($urandom_range(0, 31)), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multi-pass control stage that sits directly upstream of the 8-bit 3-stage logical-right barrel shifter. The shifter moves a byte right by at most 7 per pass. This block accepts a byte and a wider shift amount over a valid/ready request port and drives the shifter's data and control inputs. It feeds each shifter result back until the full amount has been applied, then presents the final byte on a valid/ready response port.

Parameters:
AMT_W, 5, width of requested shift amount (max amount 2^AMT_W-1)
PCNT_W, 4, width of pass counter reported with the response; must hold ceil((2^AMT_W-1)/7)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept request (high only in IDLE)
req_data  input  8  byte to shift
req_amt  input  AMT_W  total logical-right shift amount
sh_in  output  8  to shifter data input
sh_ctrl  output  3  to shifter shift-amount control
sh_out  input  8  from shifter result (combinational return path)
rsp_valid  output  1  result available
rsp_ready  input  1  consumer accepts result
rsp_data  output  8  shifted byte
rsp_passes  output  PCNT_W  number of shifter passes used
busy  output  1  high in SHIFT or DONE

Behaviour:
- Registers: data_r[7:0], rem_r[AMT_W-1:0], pcnt_r[PCNT_W-1:0], state.
- States: IDLE, SHIFT, DONE.
- Reset (sync, any state including mid-operation): state=IDLE; data_r=0; rem_r=0; pcnt_r=0. Outputs after reset: req_ready=1, rsp_valid=0, rsp_data=0, rsp_passes=0, sh_in=0, sh_ctrl=0, busy=0.
- IDLE: req_ready=1. On the edge with req_valid=1: data_r<=req_data, rem_r<=req_amt, pcnt_r<=0, go to SHIFT. When req_valid=0, stay in IDLE.
- SHIFT: step = (rem_r>=7) ? 7 : rem_r[2:0]. sh_ctrl=step, sh_in=data_r. Each edge: data_r<=sh_out, rem_r<=rem_r-step, pcnt_r<=pcnt_r+1. If rem_r-step==0, go to DONE; otherwise stay in SHIFT.
- rem_r=0 on entry to SHIFT: one identity pass (sh_ctrl=0), then DONE. Passes P = max(1, ceil(amt/7)).
- Latency: request accepted at edge T; rsp_valid rises after edge T+P. Response presented P cycles after acceptance.
- Outside SHIFT: sh_ctrl=0 and sh_in=data_r.
- DONE: rsp_valid=1, rsp_data=data_r, rsp_passes=pcnt_r. These are held stable until the edge where rsp_ready=1, then the block returns to IDLE.
- No request/response overlap: req_ready=0 in SHIFT and DONE. req_valid is ignored outside IDLE.
- rsp_ready is ignored outside DONE.
- busy = (state != IDLE).
- rem_r never underflows because step <= rem_r. pcnt_r saturates at all-ones and does not wrap.

Optional Feature:
SHIFT_SEQ_EARLY_ZERO_EN
- Defined: in SHIFT, if rem_r>=8 then data_r<=0, rem_r<=0, pcnt_r<=pcnt_r+1, go to DONE. sh_ctrl is still driven 7 in that cycle. Any amount >=8 completes in exactly 1 pass with rsp_data=0.
- Undefined: pure 7-per-pass iteration as above; amount >=8 takes ceil(amt/7) passes.

Test Plan:
- req_data=0xB5, req_amt=3 -> sh_ctrl=3 for 1 cycle; rsp_data=0x16, rsp_passes=1, rsp_valid 1 cycle after accept.
- req_data=0xB5, req_amt=0 -> one identity pass with sh_ctrl=0; rsp_data=0xB5, rsp_passes=1.
- req_data=0xFF, req_amt=10, macro undefined -> sh_ctrl sequence 7 then 3; rsp_data=0x00, rsp_passes=2. Macro defined -> sh_ctrl=7 once; rsp_data=0x00, rsp_passes=1.
- req_data=0x80, req_amt=7, rsp_ready held low 5 cycles -> rsp_data=0x01 and rsp_passes=1 stable throughout; req_ready=0 and a second req_valid ignored; IDLE one cycle after rsp_ready=1.
- req_data=0xFF, req_amt=20, rst pulsed in the second SHIFT cycle -> next cycle state=IDLE, req_ready=1, rsp_valid=0, busy=0, sh_ctrl=0. A following 0x0F/amt 2 request returns 0x03, passes=1.
- req_amt=31 (AMT_W=5), macro undefined -> 5 passes (7,7,7,7,3); rsp_passes=5, rsp_data=0.
